gate_tt_sequencer: RTL and testbench
====================================

Name: gate_tt_sequencer

Overview:
Self-test sequencer for the team's basic N-input gate cells. On a start request it drives every input combination onto the gate under test and waits a programmable settle time for each one. It then samples the gate output and builds the observed truth table. At the end it compares the result against an expected mask and reports pass/fail. It sits between a test controller (or bring-up FSM) and one instantiated gate cell.

Parameters:
N_IN, 2, number of gate inputs; vector count V = 2^N_IN; legal range 1..4.
SETTLE_CYCLES, 2, cycles each vector is held before its sample cycle; legal range 0..15.
EXPECTED, 4'b1000, expected truth table of width V. Bit i is the expected output for gate_in == i (AND = 1000, OR = 1110, XOR = 0110).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level-sampled run request.
abort  in  1  synchronous run cancel.
gate_q  in  1  output of gate under test.
gate_in  out  N_IN  inputs driven to gate under test; gate_in[N_IN-1] = A (MSB), gate_in[0] = last input.
busy  out  1  high while a run is in progress.
done  out  1  one-cycle pulse at completion of a run.
pass  out  1  observed == EXPECTED; valid from done, held until the next accepted start.
observed  out  V  captured truth table.

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. While rst_n = 0: state IDLE, gate_in = 0, busy = 0, done = 0, pass = 0, observed = 0, idx = 0, settle count = 0.
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - start = 1 and abort = 0 at an edge: accept the run. Set idx = 0, observed = 0, pass = 0, busy = 1, gate_in = 0.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES = 0.
- SETTLE: holds gate_in = idx for exactly SETTLE_CYCLES cycles, counting down, then moves to SAMPLE.
- SAMPLE: lasts one cycle. At its ending edge, observed[idx] <= gate_q.
  - If idx < V-1: idx increments, gate_in updates on the same edge, and the state returns to SETTLE (or stays in SAMPLE if SETTLE_CYCLES = 0).
  - If idx = V-1: go to IDLE with busy = 0, done = 1 for one cycle, gate_in = 0, and pass = (observed-with-final-bit == EXPECTED).
- Latency: done is high in the cycle after edge number V*(SETTLE_CYCLES+1), counting the start-accept edge as 0. Default: 12 edges.
- start while busy is ignored, with no queuing.
- start during the done cycle is accepted, because the state is already IDLE. Held start therefore gives back-to-back runs with period V*(SETTLE_CYCLES+1)+1 cycles.
- abort = 1 at any edge while busy:
  - Go to IDLE: busy = 0, gate_in = 0, no done, pass = 0.
  - observed keeps the bits captured before that edge.
  - abort wins over a simultaneous final sample, so no done and no capture that edge.
- abort and start together in IDLE: start is ignored.
- rst_n asserted mid-run: all outputs go to reset values immediately, with no done. After release the block stays IDLE until start.
- idx and the settle counter never wrap; the final vector terminates the run.

Optional Feature:
GATE_TT_SEQ_FAIL_IDX_EN
- Defined: adds outputs fail_valid (1 bit) and fail_idx (N_IN bits).
  - Both are cleared on start acceptance and on reset.
  - At the first SAMPLE edge where gate_q != EXPECTED[idx], the block sets fail_valid = 1 and fail_idx = idx.
  - Later mismatches do not overwrite them. Both hold until the next accepted start.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package gate_tt_pkg holds:
  - the state enum (IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2);
  - a function vec_count(n) returning 2^n;
  - the SETTLE_CYCLES counter width constant (4 bits).
- One sub-module, gate_tt_settle_timer: load, count-down, and expire flag.
- The FSM, index and capture logic stay in the top module.

Test Plan:
1. AND gate, defaults. Pulse start for 1 cycle.
   - gate_in steps 00, 01, 10, 11, each held 3 cycles.
   - done pulses 12 edges after accept; observed = 1000, pass = 1, busy falls with done.
2. OR gate, EXPECTED = 1000.
   - observed = 1110, pass = 0.
   - With the macro defined: fail_valid = 1, fail_idx = 01.
3. abort asserted while idx = 2, in SETTLE.
   - Next cycle: busy = 0, gate_in = 00, no done, pass = 0, observed = 0000 for AND (bits 0 and 1 captured as 0).
4. start held high continuously, AND gate.
   - done pulses every 13 cycles and pass = 1 each run.
   - A start pulse mid-run does not restart the sequence.
5. rst_n pulled low during SETTLE of idx = 1: gate_in, busy, observed and pass go to 0 with no clock edge. After release with start = 0, the block stays IDLE for 20 cycles.
6. SETTLE_CYCLES = 0, XOR gate, EXPECTED = 0110.
   - gate_in changes every cycle.
   - done comes 4 edges after accept; observed = 0110, pass = 1.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int unsigned SETTLE_W = 4;

    function automatic int unsigned vec_count(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Settle-time down-counter: loaded at the start of each vector, flags expiry at zero.
module gate_tt_settle_timer
    import gate_tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_en,
    input  logic [SETTLE_W-1:0] i_load_val,
    output logic                o_expired
);

    logic [SETTLE_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - SETTLE_W'(1);
        end
    end

    always_comb begin
        o_expired = (r_count == '0);
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks every input vector through a gate cell, captures its truth table and compares to EXPECTED.
// Optional first-mismatch reporting (fail_valid/fail_idx) when GATE_TT_SEQ_FAIL_IDX_EN is defined.
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int unsigned                    N_IN          = 2,
    parameter int unsigned                    SETTLE_CYCLES = 2,
    parameter logic [vec_count(N_IN)-1:0]     EXPECTED      = 4'b1000
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         gate_q,
    output logic [N_IN-1:0]              gate_in,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
`ifdef GATE_TT_SEQ_FAIL_IDX_EN
    output logic                         fail_valid,
    output logic [N_IN-1:0]              fail_idx,
`endif
    output logic [vec_count(N_IN)-1:0]   observed
);

    localparam int unsigned          V         = vec_count(N_IN);
    localparam logic [N_IN-1:0]      LAST_IDX  = N_IN'(V - 1);
    localparam logic [SETTLE_W-1:0]  LOAD_VAL  = (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);
    // With no settle time every vector goes straight to its sample cycle.
    localparam state_t               RUN_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_IN-1:0] r_idx;
    logic [V-1:0]    r_observed;
    logic [V-1:0]    w_obs_capt;
    logic            r_done;
    logic            r_pass;
    logic            w_accept;
    logic            w_sample;
    logic            w_last;
    logic            w_load;
    logic            w_settle_en;
    logic            w_expired;

    gate_tt_settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_en       (w_settle_en),
        .i_load_val (LOAD_VAL),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = RUN_STATE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort || (r_idx == LAST_IDX)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN_STATE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Abort suppresses the sample strobe, so an aborted final vector neither captures nor completes.
    always_comb begin
        w_accept    = (r_state == IDLE) && start && !abort;
        w_sample    = (r_state == SAMPLE) && !abort;
        w_last      = w_sample && (r_idx == LAST_IDX);
        w_load      = w_accept || (w_sample && !w_last);
        w_settle_en = (r_state == SETTLE);
        busy        = (r_state != IDLE);
        gate_in     = busy ? r_idx : '0;
        done        = r_done;
        pass        = r_pass;
        observed    = r_observed;
        w_obs_capt         = r_observed;
        w_obs_capt[r_idx]  = gate_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_observed <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_idx      <= '0;
                r_observed <= '0;
                r_pass     <= 1'b0;
            end else if (busy && abort) begin
                r_pass <= 1'b0;
            end else if (w_sample) begin
                r_observed <= w_obs_capt;
                if (w_last) begin
                    r_idx  <= '0;
                    r_done <= 1'b1;
                    r_pass <= (w_obs_capt == EXPECTED);
                end else begin
                    r_idx <= r_idx + N_IN'(1);
                end
            end
        end
    end

`ifdef GATE_TT_SEQ_FAIL_IDX_EN
    logic            r_fail_valid;
    logic [N_IN-1:0] r_fail_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else if (w_accept) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else if (w_sample && !r_fail_valid && (gate_q != EXPECTED[r_idx])) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_idx;
        end
    end

    always_comb begin
        fail_valid = r_fail_valid;
        fail_idx   = r_fail_idx;
    end
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: cycle-level reference model plus directed and random scenarios.
module tb_gate_tt_sequencer;

    localparam int        V   = 4;
    localparam int        PER = 3;           // SETTLE_CYCLES + 1 for the main instance
    localparam logic [3:0] EXP = 4'b1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] tt    = 4'b1000;
    logic       gate_q;
    logic [1:0] gate_in;
    logic       busy, done, pass;
    logic [3:0] observed;

    logic       start0 = 1'b0;
    logic [3:0] tt0    = 4'b0110;
    logic       gate_q0;
    logic [1:0] gate_in0;
    logic       busy0, done0, pass0;
    logic [3:0] observed0;

`ifdef GATE_TT_SEQ_FAIL_IDX_EN
    logic       fail_valid, fail_valid0;
    logic [1:0] fail_idx, fail_idx0;
`endif

    assign gate_q  = tt[gate_in];
    assign gate_q0 = tt0[gate_in0];

    always #5 clk = ~clk;

    gate_tt_sequencer #(.N_IN(2), .SETTLE_CYCLES(2), .EXPECTED(4'b1000)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_q(gate_q),
        .gate_in(gate_in), .busy(busy), .done(done), .pass(pass),
`ifdef GATE_TT_SEQ_FAIL_IDX_EN
        .fail_valid(fail_valid), .fail_idx(fail_idx),
`endif
        .observed(observed)
    );

    gate_tt_sequencer #(.N_IN(2), .SETTLE_CYCLES(0), .EXPECTED(4'b0110)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .gate_q(gate_q0),
        .gate_in(gate_in0), .busy(busy0), .done(done0), .pass(pass0),
`ifdef GATE_TT_SEQ_FAIL_IDX_EN
        .fail_valid(fail_valid0), .fail_idx(fail_idx0),
`endif
        .observed(observed0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: run progress is just "edges since accept"; vector j is sampled at edge (j+1)*PER.
    logic       m_run  = 1'b0;
    int         m_k    = 0;
    logic [3:0] m_obs  = '0;
    logic       m_pass = 1'b0;
    logic       m_done = 1'b0;
    logic       m_fv   = 1'b0;
    logic [1:0] m_fi   = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic       run, done_n, pass_n, fv;
        logic [3:0] obs;
        logic [1:0] fi;
        int         k, j;
        if (!rst_n) begin
            m_run <= 1'b0; m_k <= 0; m_obs <= '0; m_pass <= 1'b0;
            m_done <= 1'b0; m_fv <= 1'b0; m_fi <= '0;
        end else begin
            run = m_run; k = m_k; obs = m_obs; pass_n = m_pass; fv = m_fv; fi = m_fi;
            done_n = 1'b0;
            if (run) begin
                if (abort) begin
                    run = 1'b0; pass_n = 1'b0;
                end else begin
                    k = k + 1;
                    if (k % PER == 0) begin
                        j = k / PER - 1;
                        obs[j] = tt[j];
                        if (!fv && (tt[j] != EXP[j])) begin fv = 1'b1; fi = 2'(j); end
                        if (j == V - 1) begin run = 1'b0; done_n = 1'b1; pass_n = (obs == EXP); end
                    end
                end
            end else if (start && !abort) begin
                run = 1'b1; k = 0; obs = '0; pass_n = 1'b0; fv = 1'b0; fi = '0;
            end
            m_run <= run; m_k <= k; m_obs <= obs; m_pass <= pass_n;
            m_done <= done_n; m_fv <= fv; m_fi <= fi;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] exp_gi;
        if (rst_n) begin
            exp_gi = m_run ? 2'(m_k / PER) : 2'b00;
            check("busy", busy, m_run);
            check("gate_in", gate_in, exp_gi);
            check("done", done, m_done);
            check("pass", pass, m_pass);
            check("observed", observed, m_obs);
`ifdef GATE_TT_SEQ_FAIL_IDX_EN
            check("fail_valid", fail_valid, m_fv);
            check("fail_idx", fail_idx, m_fi);
`endif
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done) begin cyc = i; return; end
        end
    endtask

    initial begin
        int         cyc;
        int         n_busy, n_done;
        int         d_at[3];
        int         nd;
        logic [1:0] gi_seen[13];

        #2;
        check("rst_busy", busy, 0);
        check("rst_gate_in", gate_in, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_observed", observed, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: AND gate, each vector held 3 cycles, done 12 edges after accept
        tt = 4'b1000;
        pulse_start();
        check("t1_busy_accept", busy, 1);
        check("t1_gi_accept", gate_in, 0);
        cyc = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            gi_seen[i] = gate_in;
            if (done && cyc < 0) cyc = i;
        end
        check("t1_gi_e2", gi_seen[2], 0);
        check("t1_gi_e3", gi_seen[3], 1);
        check("t1_gi_e6", gi_seen[6], 2);
        check("t1_gi_e11", gi_seen[11], 3);
        check("t1_gi_e12", gi_seen[12], 0);
        check("t1_latency", cyc, 12);
        check("t1_observed", observed, 4'b1000);
        check("t1_pass", pass, 1);
        check("t1_busy_done", busy, 0);
        @(negedge clk);
        check("t1_done_1cyc", done, 0);
        check("t1_pass_hold", pass, 1);

        // 2: OR gate against AND expectation
        tt = 4'b1110;
        pulse_start();
        wait_done(40, cyc);
        check("t2_latency", cyc, 12);
        check("t2_observed", observed, 4'b1110);
        check("t2_pass", pass, 0);
`ifdef GATE_TT_SEQ_FAIL_IDX_EN
        check("t2_fail_valid", fail_valid, 1);
        check("t2_fail_idx", fail_idx, 1);
`endif

        // 3: abort during SETTLE of idx 2 (AND), then with all-ones gate
        tt = 4'b1000;
        pulse_start();
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t3_busy", busy, 0);
        check("t3_gate_in", gate_in, 0);
        check("t3_done", done, 0);
        check("t3_pass", pass, 0);
        check("t3_observed", observed, 4'b0000);
        tt = 4'b1111;
        pulse_start();
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t3b_observed", observed, 4'b0011);
        // abort on the final sample edge: no capture, no done
        pulse_start();
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t3c_busy", busy, 0);
        check("t3c_observed", observed, 4'b0111);
        n_done = (done === 1'b1) ? 1 : 0;
        repeat (5) begin @(negedge clk); if (done) n_done++; end
        check("t3c_no_done", n_done, 0);

        // 4: start held high -> back-to-back runs every 13 cycles
        tt = 4'b1000;
        nd = 0;
        @(negedge clk) start = 1'b1;
        for (int i = 1; i <= 44; i++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 3) d_at[nd] = i;
                nd++;
                check("t4_pass", pass, 1);
            end
        end
        check("t4_ndone", nd, 3);
        check("t4_first", d_at[0], 13);
        check("t4_period1", d_at[1] - d_at[0], 13);
        check("t4_period2", d_at[2] - d_at[1], 13);
        start = 1'b0;
        wait_done(30, cyc);
        check("t4_tail_done", (cyc > 0) ? 1 : 0, 1);

        // 5: asynchronous reset during SETTLE of idx 1
        tt = 4'b1111;
        pulse_start();
        repeat (4) @(negedge clk);
        check("t5_pre_observed", observed, 4'b0001);
        check("t5_pre_gi", gate_in, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_gate_in", gate_in, 0);
        check("t5_observed", observed, 0);
        check("t5_pass", pass, 0);
        check("t5_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        n_busy = 0; n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) n_done++;
        end
        check("t5_idle_busy", n_busy, 0);
        check("t5_idle_done", n_done, 0);

        // 6: zero settle time, XOR gate, second instance
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        check("t6_gi0", gate_in0, 0);
        cyc = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) check("t6_gi_step", gate_in0, 32'(i));
            if (done0 && cyc < 0) cyc = i;
        end
        check("t6_latency", cyc, 4);
        check("t6_observed", observed0, 4'b0110);
        check("t6_pass", pass0, 1);
        check("t6_busy", busy0, 0);
`ifdef GATE_TT_SEQ_FAIL_IDX_EN
        check("t6_fail_valid", fail_valid0, 0);
`endif

        // Random phase: random starts, aborts and gate functions against the model
        n_done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) n_done++;
            start = ($urandom % 4) == 0;
            abort = ($urandom % 40) == 0;
            if (($urandom % 16) == 0) tt = 4'($urandom);
        end
        check("rand_runs_seen", (n_done > 0) ? 1 : 0, 1);
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
